// File: rtl/branch_predictor_btb.sv
`default_nettype none
// branch_predictor_btb: direct-mapped BTB plus saturating-counter BHT, optionally gshare-indexed.
// Revision: 1.0
module branch_predictor_btb #(
  parameter  int ENTRIES = 64,
  parameter  int CNT_W   = 2,
  parameter  int HIST_W  = 0,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hold,
  input  logic [31:0]      i_pc_if,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_target,
  output logic [IDX_W-1:0] o_pred_idx,
  input  logic             i_upd_valid,
  input  logic [31:0]      i_upd_pc,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic [31:0]      i_upd_target,
  input  logic             i_upd_pred_taken,
  input  logic [31:0]      i_upd_pred_target,
  output logic             o_mispredict,
  output logic [31:0]      o_br_count,
  output logic [31:0]      o_miss_count
);

  localparam int               TAG_W      = 30 - IDX_W;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_INIT = c_CNT_MAX >> 1;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];
  logic [31:0]      r_br_count;
  logic [31:0]      r_miss_count;

  logic [IDX_W-1:0] w_bi;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_upd_bi;
  logic [TAG_W-1:0] w_upd_tag;
  logic [IDX_W-1:0] w_hist_ext;
  logic             w_hit;
  logic             w_upd_en;
  logic             w_unused;

  assign w_bi      = i_pc_if[IDX_W+1:2];
  assign w_tag     = i_pc_if[31:IDX_W+2];
  assign w_upd_bi  = i_upd_pc[IDX_W+1:2];
  assign w_upd_tag = i_upd_pc[31:IDX_W+2];
  assign w_upd_en  = i_upd_valid && !i_hold;
  assign w_unused  = ^{i_pc_if[1:0], i_upd_pc[1:0]};

  // History only advances on resolved instructions, so it never needs repair.
  if (HIST_W == 0) begin : g_bimodal
    assign w_hist_ext = '0;
  end else begin : g_gshare
    logic [HIST_W-1:0] r_ghr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ghr <= '0;
      end else if (w_upd_en) begin
        r_ghr <= (r_ghr << 1) | HIST_W'(i_upd_taken);
      end
    end
    assign w_hist_ext = IDX_W'(r_ghr);
  end

  assign w_hit         = r_valid[w_bi] && (r_tag[w_bi] == w_tag);
  assign o_pred_idx    = w_bi ^ w_hist_ext;
  assign o_pred_taken  = w_hit && r_cnt[o_pred_idx][CNT_W-1];
  assign o_pred_target = o_pred_taken ? r_target[w_bi] : i_pc_if + 32'd4;

  assign o_mispredict = i_upd_valid &&
                        ((i_upd_taken != i_upd_pred_taken) ||
                         (i_upd_taken && (i_upd_target != i_upd_pred_target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= c_CNT_INIT;
      end
    end else if (w_upd_en) begin
      if (i_upd_taken) begin
        r_valid[w_upd_bi] <= 1'b1;
        if (r_cnt[i_upd_idx] != c_CNT_MAX) begin
          r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] + CNT_W'(1);
        end
      end else if (r_cnt[i_upd_idx] != '0) begin
        r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] - CNT_W'(1);
      end
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_upd_en && i_upd_taken) begin
      r_tag[w_upd_bi]    <= w_upd_tag;
      r_target[w_upd_bi] <= i_upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else if (w_upd_en) begin
      r_br_count <= r_br_count + 32'd1;
      if (o_mispredict) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign o_br_count   = r_br_count;
  assign o_miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// tb_branch_predictor_btb: bimodal and gshare instances checked against a behavioural model.
// Revision: 1.0
module tb_branch_predictor_btb;

  localparam int N = 64;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [31:0] pc_if;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [5:0]  upd_idx  [2];
  logic        upd_pt   [2];
  logic [31:0] upd_ptgt [2];

  logic        pt_o   [2];
  logic [31:0] ptg_o  [2];
  logic [5:0]  pidx_o [2];
  logic        mp_o   [2];
  logic [31:0] br_o   [2];
  logic [31:0] miss_o [2];

  int n_chk  = 0;
  int n_fail = 0;

  branch_predictor_btb #(.ENTRIES(64), .CNT_W(2), .HIST_W(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_hold(hold), .i_pc_if(pc_if),
    .o_pred_taken(pt_o[0]), .o_pred_target(ptg_o[0]), .o_pred_idx(pidx_o[0]),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_idx(upd_idx[0]),
    .i_upd_taken(upd_taken), .i_upd_target(upd_target),
    .i_upd_pred_taken(upd_pt[0]), .i_upd_pred_target(upd_ptgt[0]),
    .o_mispredict(mp_o[0]), .o_br_count(br_o[0]), .o_miss_count(miss_o[0])
  );

  branch_predictor_btb #(.ENTRIES(64), .CNT_W(2), .HIST_W(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .i_hold(hold), .i_pc_if(pc_if),
    .o_pred_taken(pt_o[1]), .o_pred_target(ptg_o[1]), .o_pred_idx(pidx_o[1]),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_idx(upd_idx[1]),
    .i_upd_taken(upd_taken), .i_upd_target(upd_target),
    .i_upd_pred_taken(upd_pt[1]), .i_upd_pred_target(upd_ptgt[1]),
    .o_mispredict(mp_o[1]), .o_br_count(br_o[1]), .o_miss_count(miss_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: index 0 is the bimodal instance, 1 the gshare instance.
  bit          m_valid [2][N];
  logic [31:0] m_tag   [2][N];
  logic [31:0] m_tgt   [2][N];
  int          m_cnt   [2][N];
  int          m_ghr   [2];
  logic [31:0] m_br    [2];
  logic [31:0] m_miss  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        m_valid[m][i] = 1'b0;
        m_cnt[m][i]   = 1;
        m_tag[m][i]   = '0;
        m_tgt[m][i]   = '0;
      end
      m_ghr[m]  = 0;
      m_br[m]   = '0;
      m_miss[m] = '0;
    end
  endtask

  function automatic int mdl_bi(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd64);
  endfunction

  function automatic int mdl_idx(input int m, input logic [31:0] pc);
    return (m == 1) ? (mdl_bi(pc) ^ m_ghr[1]) : mdl_bi(pc);
  endfunction

  function automatic bit mdl_taken(input int m, input logic [31:0] pc);
    int bi;
    bi = mdl_bi(pc);
    return m_valid[m][bi] && (m_tag[m][bi] == (pc >> 8)) && (m_cnt[m][mdl_idx(m, pc)] >= 2);
  endfunction

  function automatic logic [31:0] mdl_target(input int m, input logic [31:0] pc);
    return mdl_taken(m, pc) ? m_tgt[m][mdl_bi(pc)] : pc + 32'd4;
  endfunction

  function automatic bit mdl_mispred(input int m);
    return upd_valid && ((upd_taken != upd_pt[m]) || (upd_taken && (upd_target != upd_ptgt[m])));
  endfunction

  task automatic mdl_update(input int m);
    int bi;
    int ix;
    bi = mdl_bi(upd_pc);
    ix = int'(upd_idx[m]);
    if (mdl_mispred(m)) m_miss[m] = m_miss[m] + 32'd1;
    m_br[m] = m_br[m] + 32'd1;
    if (upd_taken) begin
      m_cnt[m][ix]  = (m_cnt[m][ix] == 3) ? 3 : m_cnt[m][ix] + 1;
      m_valid[m][bi] = 1'b1;
      m_tag[m][bi]   = upd_pc >> 8;
      m_tgt[m][bi]   = upd_target;
    end else begin
      m_cnt[m][ix] = (m_cnt[m][ix] == 0) ? 0 : m_cnt[m][ix] - 1;
    end
    if (m == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(upd_taken)) & 3;
  endtask

  always @(posedge clk) begin
    if (rst_n && upd_valid && !hold) begin
      for (int m = 0; m < 2; m++) mdl_update(m);
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      string nm;
      nm = (m == 0) ? "bim" : "gsh";
      chk({nm, ".pred_taken"},  32'(pt_o[m]),   32'(mdl_taken(m, pc_if)));
      chk({nm, ".pred_target"}, ptg_o[m],       mdl_target(m, pc_if));
      chk({nm, ".pred_idx"},    32'(pidx_o[m]), 32'(mdl_idx(m, pc_if)));
      chk({nm, ".mispredict"},  32'(mp_o[m]),   32'(mdl_mispred(m)));
      chk({nm, ".br_count"},    br_o[m],        m_br[m]);
      chk({nm, ".miss_count"},  miss_o[m],      m_miss[m]);
    end
  end

  task automatic cyc(input logic [31:0] pc, input bit v, input logic [31:0] upc, input bit tk,
                     input logic [31:0] tgt, input bit hd, input bit use_mdl, input bit pt,
                     input logic [31:0] ptgt);
    @(posedge clk);
    #1;
    pc_if      = pc;
    upd_valid  = v;
    upd_pc     = upc;
    upd_taken  = tk;
    upd_target = tgt;
    hold       = hd;
    for (int m = 0; m < 2; m++) begin
      upd_idx[m]  = 6'(mdl_idx(m, upc));
      upd_pt[m]   = use_mdl ? mdl_taken(m, upc) : pt;
      upd_ptgt[m] = use_mdl ? mdl_target(m, upc) : ptgt;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc);
    cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 5))
      0: return 32'h100;
      1: return 32'h200;
      2: return 32'h104;
      3: return 32'h300;
      4: return 32'h1F0;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    mdl_reset();
    hold = 1'b0; pc_if = 32'h100; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0;
    for (int m = 0; m < 2; m++) begin
      upd_idx[m] = '0; upd_pt[m] = 1'b0; upd_ptgt[m] = '0;
    end

    // Reset state, before any rising edge
    #2;
    chk("rst.pred_taken",  32'(pt_o[0]), 32'd0);
    chk("rst.pred_target", ptg_o[0],     32'h104);
    chk("rst.br_count",    br_o[0],      32'd0);
    chk("rst.miss_count",  miss_o[0],    32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Learn a taken branch
    cyc(32'h100, 1, 32'h100, 1, 32'h40, 0, 0, 0, 32'h104);
    chk("learn.mispredict1", 32'(mp_o[0]), 32'd1);
    cyc(32'h100, 1, 32'h100, 1, 32'h40, 0, 0, 0, 32'h104);
    idle(32'h100);
    chk("learn.pred_taken",  32'(pt_o[0]), 32'd1);
    chk("learn.pred_target", ptg_o[0],     32'h40);
    chk("learn.miss_count",  miss_o[0],    32'd2);

    // Saturation
    repeat (5) cyc(32'h100, 1, 32'h100, 1, 32'h40, 0, 0, 1, 32'h40);
    idle(32'h100);
    chk("sat.taken5", 32'(pt_o[0]), 32'd1);
    cyc(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, 1, 32'h40);
    idle(32'h100);
    chk("sat.nt1", 32'(pt_o[0]), 32'd1);
    cyc(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, 1, 32'h40);
    idle(32'h100);
    chk("sat.nt2",        32'(pt_o[0]), 32'd0);
    chk("sat.nt2_target", ptg_o[0],     32'h104);

    // Aliasing and tag miss
    repeat (2) cyc(32'h100, 1, 32'h100, 1, 32'h40, 0, 0, 0, 32'h104);
    idle(32'h200);
    chk("alias.pred_taken",  32'(pt_o[0]), 32'd0);
    chk("alias.pred_target", ptg_o[0],     32'h204);
    idle(32'h100);
    chk("alias.orig_taken",  32'(pt_o[0]), 32'd1);
    chk("alias.br_count",    br_o[0],      32'd11);

    // Hold suppresses state but not the redirect
    cyc(32'h100, 1, 32'h100, 0, 32'h0, 1, 0, 1, 32'h40);
    chk("hold.mispredict", 32'(mp_o[0]), 32'd1);
    idle(32'h100);
    chk("hold.pred_taken", 32'(pt_o[0]), 32'd1);
    chk("hold.br_count",   br_o[0],      32'd11);

    // Same-cycle lookup and update: read before write
    cyc(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, 1, 32'h40);
    cyc(32'h100, 1, 32'h100, 0, 32'h0, 0, 0, 1, 32'h40);
    chk("rbw.old", 32'(pt_o[0]), 32'd1);
    idle(32'h100);
    chk("rbw.new",        32'(pt_o[0]), 32'd0);
    chk("rbw.br_count",   br_o[0],      32'd13);
    chk("rbw.miss_count", miss_o[0],    32'd8);

    // Gshare learns an alternating pattern
    for (int k = 1; k <= 16; k++) begin
      cyc(32'h100, 1, 32'h100, (k % 2) == 1, 32'h40, 0, 1, 0, 32'h0);
      chk("gsh.bim_idx", 32'(pidx_o[0]), 32'd0);
      if (k > 12) chk("gsh.no_mispredict", 32'(mp_o[1]), 32'd0);
      if (k == 15) chk("gsh.idx_taken", 32'(pidx_o[1]), 32'd2);
      if (k == 16) chk("gsh.idx_not_taken", 32'(pidx_o[1]), 32'd1);
    end

    // Randomized traffic, with a reset pulse in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        upd_valid = 1'b0;
        mdl_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      cyc(pick_pc(), $urandom_range(0, 1) == 1, pick_pc(), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'h40,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, 32'h40);
    end

    idle(32'h100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised dynamic branch predictor for the RV32I pipeline. It combines a direct-mapped branch target buffer (BTB) with a table of saturating counters (BHT), and optionally indexes the BHT gshare-style using a global history register. It is looked up combinationally in IF from the current fetch PC. It is updated in EX when a branch or jal/jalr resolves, and it reports mispredictions plus branch and mispredict counts for the hazard unit and for debug.

## Interface
Parameters:
- ENTRIES, 64: BTB and BHT depth; power of two, 4..1024. IDX_W = log2(ENTRIES).
- CNT_W, 2: width of each saturating counter, 1..4.
- HIST_W, 0: global history length. 0 selects bimodal indexing; 1..IDX_W selects gshare indexing.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  pipeline freeze (cache miss). While high, all state updates are suppressed.
- pc_if  in  32  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
- pred_idx  out  IDX_W  BHT index used for this prediction; the pipeline carries it to EX.
- upd_valid  in  1  one-cycle pulse marking a resolved control-flow instruction in EX.
- upd_pc  in  32  PC of the resolved instruction.
- upd_idx  in  IDX_W  pred_idx carried down the pipeline with that instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target.
- upd_pred_taken  in  1  prediction carried down with the instruction.
- upd_pred_target  in  32  predicted target carried down with the instruction.
- mispredict  out  1  combinational redirect request.
- br_count  out  32  number of resolved control-flow instructions.
- miss_count  out  32  number of mispredictions.

## Operation
Address slicing:
- BTB index bi = pc[IDX_W+1:2].
- Tag = pc[31:IDX_W+2].
- BHT index for lookup: bi when HIST_W = 0; otherwise bi XOR {zero-extend(ghr)}.

Lookup (combinational, in IF):
- hit = valid[bi] && tag[bi] == pc_if tag.
- pred_taken = hit && the MSB of bht[pred_idx].
- pred_target = pred_taken ? btb_target[bi] : pc_if + 4.

Update (on each clock edge where upd_valid && !hold):
- bht[upd_idx]: increment if upd_taken, otherwise decrement. Saturate at 0 and at 2^CNT_W − 1.
- If upd_taken: write the BTB entry at upd_pc's index with valid = 1, the upd_pc tag and upd_target. This overwrites any entry already there.
- If not taken: the BTB entry is left unchanged.
- If HIST_W > 0: ghr <= {ghr[HIST_W−2:0], upd_taken}. History is non-speculative.
- br_count increments by 1.
- If mispredict, miss_count increments by 1.
- Both counters wrap modulo 2^32.

mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)). It is asserted regardless of hold.

## Timing
- Reset (rst low, asynchronous):
  - all valid bits = 0;
  - all counters = 2^(CNT_W−1) − 1 (weakly not-taken);
  - ghr = 0;
  - br_count = 0 and miss_count = 0.
- Consequence of reset: pred_taken = 0 and pred_target = pc_if + 4 immediately, with no clock edge required.
- Lookup is zero latency. An update written at edge N is visible to a lookup from cycle N+1 onward.
- Lookup and update to the same entry in the same cycle: the lookup returns the pre-update value (read before write).
- hold high together with upd_valid: no table, history or counter change. mispredict is still driven, so the redirect is not lost.
- upd_valid held high for k cycles with hold low counts as k updates. The caller must pulse it once per instruction.
- Reset released mid-operation: the first update is accepted at the first rising edge after rst goes high.

## Test plan
- **Reset state.** Assert rst low, then release. Drive pc_if = 0x100 -> pred_taken = 0, pred_target = 0x104, br_count = 0, miss_count = 0.
- **Learn a taken branch.** Defaults. Send 2 updates: upd_pc = 0x100, taken, target 0x40, pred not-taken.
  - -> mispredict = 1 on the first update.
  - -> then pc_if = 0x100 gives pred_taken = 1, pred_target = 0x40.
  - -> miss_count = 1 or 2 as appropriate (the second update also predicted not-taken).
- **Saturation.** Send 5 taken updates, then 1 not-taken, on the same index -> the counter reads 3, 3, 3 after saturating, then 2; pred_taken stays 1. A second not-taken update -> counter 1, pred_taken = 0.
- **Aliasing and tag miss.** Train 0x100 taken (target 0x40), then look up 0x200 (same index, different tag) -> pred_taken = 0, pred_target = 0x204.
- **Hold and same-cycle read/write.**
  - Update 0x100 with hold = 1 -> no state change, but mispredict is driven.
  - Update 0x100 while pc_if = 0x100 in the same cycle -> the old prediction is returned that cycle and the new one the next cycle.
- **Gshare.** HIST_W = 2. Send an alternating taken/not-taken pattern at 0x100 for 16 updates -> after warm-up, mispredict = 0 on each of the last 4 updates; pred_idx differs from bi as ghr changes.
